// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is registered reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign wr_acc       = wr_en & ~full;
  assign rd_acc       = rd_en & ~empty;
  assign empty        = count == '0;
  assign full         = count == CW'(DEPTH);
  assign almost_empty = count <= CW'(AE_THRESH);
  assign almost_full  = count >= CW'(AF_THRESH);
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(wr_acc);
      rd_ptr    <= rd_ptr + AW'(rd_acc);
      count     <= (wr_acc & ~rd_acc) ? count + CW'(1) : (rd_acc & ~wr_acc) ? count - CW'(1) : count;
      overflow  <= ~err_clr & (overflow | (wr_en & full));
      underflow <= ~err_clr & (underflow | (rd_en & empty));
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed table plus randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int DW = 8, D = 16, AF = 12, AE = 4;
  logic clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] ctl;
    int         n;
    logic [7:0] d0;
    int         cnt;
    logic [5:0] flg;
    logic [7:0] rd;
  } vec_t;
  vec_t vec [12];
  int tests = 0, fails = 0;
  logic [7:0] q [$];
  logic m_ov = 1'b0, m_un = 1'b0, m_rv = 1'b0;
  logic [7:0] m_rd = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_model();
    int n = q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == D));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_valid", 32'(rd_valid), 32'(n != 0));
    if (n != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`else
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
`endif
  endtask
  task automatic cyc();
    bit f = q.size() == D;
    bit e = q.size() == 0;
    @(posedge clk);
    if (rd_en && !e) begin
      m_rd = q.pop_front();
      m_rv = 1'b1;
    end else m_rv = 1'b0;
    if (wr_en && !f) q.push_back(wr_data);
    if (err_clr) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (wr_en && f) m_ov = 1'b1;
      if (rd_en && e) m_un = 1'b1;
    end
    #1;
    cmp_model();
  endtask
  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    m_rv = 1'b0;
    m_rd = '0;
  endtask
  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
  endtask
  initial begin
    // {wr,rd,clr}, cycles, first data, then count, {full,empty,ae,af,ovf,udf}, rd_data after the phase
    vec[0]  = '{3'b100,  5, 8'h00, 5,  6'b000000, 8'h00};
    vec[1]  = '{3'b100,  7, 8'h05, 12, 6'b000100, 8'h00};
    vec[2]  = '{3'b100,  4, 8'h0C, 16, 6'b100100, 8'h00};
    vec[3]  = '{3'b100,  1, 8'hAA, 16, 6'b100110, 8'h00};
    vec[4]  = '{3'b010, 16, 8'h00, 0,  6'b011010, 8'h0F};
    vec[5]  = '{3'b010,  1, 8'h00, 0,  6'b011011, 8'h0F};
    vec[6]  = '{3'b100, 16, 8'h10, 16, 6'b100111, 8'h0F};
    vec[7]  = '{3'b101,  1, 8'hBB, 16, 6'b100100, 8'h0F};
    vec[8]  = '{3'b010,  8, 8'h00, 8,  6'b000000, 8'h17};
    vec[9]  = '{3'b110, 40, 8'h20, 8,  6'b000000, 8'h3F};
    vec[10] = '{3'b010,  8, 8'h00, 0,  6'b011000, 8'h47};
    vec[11] = '{3'b110,  1, 8'hC0, 1,  6'b001001, 8'h47};
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vec[i].n; k++) begin
        {wr_en, rd_en, err_clr} = vec[i].ctl;
        wr_data = vec[i].d0 + 8'(k);
        cyc();
      end
      idle();
      chk($sformatf("v%0d count", i), 32'(count), vec[i].cnt);
      chk($sformatf("v%0d flags", i), 32'({full, empty, almost_empty, almost_full, overflow, underflow}), 32'(vec[i].flg));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vec[i].rd));
`endif
    end
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1;
      wr_data = 8'hD0 + 8'(k);
      cyc();
    end
    chk("pre-reset count", 32'(count), 9);
    rd_en = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async count", 32'(count), 0);
    chk("async flags", 32'({full, empty, almost_empty, almost_full, overflow, underflow}), 32'(6'b011000));
    chk("async rd_valid", 32'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("async rd_data", 32'(rd_data), 0);
`endif
    @(posedge clk);
    #1;
    cmp_model();
    idle();
    rst_n = 1'b1;
    rd_en = 1'b1;
    cyc();
    chk("post-reset read rejected", 32'(underflow), 1);
    idle();
    err_clr = 1'b1;
    cyc();
    idle();
`ifdef SYNC_FIFO_FWFT_EN
    wr_en = 1'b1;
    wr_data = 8'h5A;
    cyc();
    idle();
    chk("fwft rd_data", 32'(rd_data), 32'h5A);
    chk("fwft rd_valid", 32'(rd_valid), 1);
    rd_en = 1'b1;
    cyc();
    idle();
    chk("fwft pop empty", 32'(empty), 1);
`else
    wr_en = 1'b1;
    wr_data = 8'hE1;
    cyc();
    idle();
    rd_en = 1'b1;
    cyc();
    idle();
    chk("first post-reset read", 32'(rd_data), 32'hE1);
    chk("first post-reset valid", 32'(rd_valid), 1);
`endif
    for (int b = 0; b < 6; b++) begin
      int pw = $urandom_range(10, 90);
      int pr = $urandom_range(10, 90);
      for (int k = 0; k < 400; k++) begin
        wr_en = $urandom_range(0, 99) < pw;
        rd_en = $urandom_range(0, 99) < pr;
        err_clr = $urandom_range(0, 39) == 0;
        wr_data = 8'($urandom);
        cyc();
      end
    end
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
